// File: rtl/csr_unit.sv
// csr_unit: M-mode CSR file with 64-bit counters, trap/MRET sequencing and interrupt arbitration.
// Build option: define COTM32_CSR_HPM_EN to implement the mhpmcounter3+ counters.

package zicsr_pkg;
  typedef enum logic [1:0] {CSR_NONE = 2'd0, CSR_RW = 2'd1, CSR_RS = 2'd2, CSR_RC = 2'd3} zicsr_csr_op_t;
endpackage

module csr_unit
  import zicsr_pkg::*;
#(
  parameter int               MXLEN          = 32,
  parameter int               NUM_HPM        = 4,
  parameter bit               MTVEC_VECTORED = 1'b1,
  parameter logic [MXLEN-1:0] RESET_MTVEC    = '0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  zicsr_csr_op_t      i_op,
  input  logic [11:0]        i_addr,
  input  logic               i_we,
  input  logic [MXLEN-1:0]   i_wdata,
  input  logic [MXLEN-1:0]   i_pc,
  input  logic               i_trap_req,
  input  logic [MXLEN-1:0]   i_trap_cause,
  input  logic [MXLEN-1:0]   i_trap_tval,
  input  logic               i_trap_mret,
  input  logic               i_retire,
  input  logic               i_msip,
  input  logic               i_mtip,
  input  logic               i_meip,
  input  logic [NUM_HPM-1:0] i_hpm_evt,
  output logic [MXLEN-1:0]   o_rdata,
  output logic [MXLEN-1:0]   o_mstatus,
  output logic [MXLEN-1:0]   o_mie,
  output logic [MXLEN-1:0]   o_mip,
  output logic [MXLEN-1:0]   o_mepc,
  output logic [MXLEN-1:0]   o_trap_vec,
  output logic               o_irq_pending,
  output logic [MXLEN-1:0]   o_irq_cause,
  output logic               o_t_illegal_inst
);

  localparam logic [1:0]       MXL  = (MXLEN == 64) ? 2'd2 : 2'd1;
  localparam logic [MXLEN-1:0] MISA = {MXL, {(MXLEN-2){1'b0}}} | MXLEN'(9'h100);
`ifdef COTM32_CSR_HPM_EN
  localparam logic [63:0]      HPM_BITS = ((64'd1 << NUM_HPM) - 64'd1) << 3;
`else
  localparam logic [63:0]      HPM_BITS = '0;
`endif
  localparam logic [MXLEN-1:0] MCI_MASK = MXLEN'(HPM_BITS | 64'h5);

  logic             r_st_mie, r_st_mpie;
  logic [2:0]       r_mie_en, r_mip;        // {MEI, MTI, MSI}
  logic [MXLEN-1:0] r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval, r_mcinh;
  logic [63:0]      r_mcycle, r_minstret;

  logic [MXLEN-1:0] w_old, w_wval, w_base;
  logic             w_impl, w_illegal, w_wr;
  logic [2:0]       w_pend;
  logic [3:0]       w_code;

  // Counter write replaces only the addressed half and suppresses that cycle's increment.
  function automatic logic [63:0] cnt_next(input logic [63:0] c, input logic wl, input logic wh,
                                           input logic inc, input logic [MXLEN-1:0] wv);
    logic [63:0] w64;
    w64 = 64'(wv);
    if (wl) return (MXLEN == 64) ? w64 : {c[63:32], w64[31:0]};
    if (wh) return {w64[31:0], c[31:0]};
    if (inc) return c + 64'd1;
    return c;
  endfunction

  assign o_mstatus = MXLEN'({2'b11, 3'b0, r_st_mpie, 3'b0, r_st_mie, 3'b0});
  assign o_mie     = MXLEN'({r_mie_en[2], 3'b0, r_mie_en[1], 3'b0, r_mie_en[0], 3'b0});
  assign o_mip     = MXLEN'({r_mip[2], 3'b0, r_mip[1], 3'b0, r_mip[0], 3'b0});
  assign o_mepc    = r_mepc;

`ifdef COTM32_CSR_HPM_EN
  logic [63:0]        r_hpm [NUM_HPM];
  logic [NUM_HPM-1:0] w_hpm_wl, w_hpm_wh;
`else
  logic w_unused_hpm;
  assign w_unused_hpm = ^i_hpm_evt;
`endif

  always_comb begin
    w_old  = '0;
    w_impl = 1'b1;
    case (i_addr)
      12'h300: w_old = o_mstatus;
      12'h301: w_old = MISA;
      12'h304: w_old = o_mie;
      12'h305: w_old = r_mtvec;
      12'h320: w_old = r_mcinh;
      12'h340: w_old = r_mscratch;
      12'h341: w_old = r_mepc;
      12'h342: w_old = r_mcause;
      12'h343: w_old = r_mtval;
      12'h344: w_old = o_mip;
      12'hF14: w_old = '0;
      12'hB00: w_old = MXLEN'(r_mcycle);
      12'hB02: w_old = MXLEN'(r_minstret);
      12'hB80: if (MXLEN == 32) w_old = MXLEN'(r_mcycle[63:32]);   else w_impl = 1'b0;
      12'hB82: if (MXLEN == 32) w_old = MXLEN'(r_minstret[63:32]); else w_impl = 1'b0;
      default: begin
        w_impl = 1'b0;
        if ((i_addr[11:5] == 7'b1011000 || (MXLEN == 32 && i_addr[11:5] == 7'b1011100))
            && i_addr[4:0] >= 5'd3) begin
`ifdef COTM32_CSR_HPM_EN
          for (int k = 0; k < NUM_HPM; k++) begin
            if (i_addr[4:0] == 5'(k + 3)) begin
              w_impl = 1'b1;
              w_old  = i_addr[7] ? MXLEN'(r_hpm[k][63:32]) : MXLEN'(r_hpm[k]);
            end
          end
`else
          w_impl = 1'b1;
`endif
        end
      end
    endcase
  end

  assign o_rdata          = w_old;
  assign w_illegal        = (i_op != CSR_NONE) && (!w_impl || (i_we && i_addr[11:10] == 2'b11));
  assign o_t_illegal_inst = w_illegal;
  assign w_wr = i_we && (i_op != CSR_NONE) && !w_illegal && !i_trap_req && !i_trap_mret;

  always_comb begin
    case (i_op)
      CSR_RS:  w_wval = w_old | i_wdata;
      CSR_RC:  w_wval = w_old & ~i_wdata;
      default: w_wval = i_wdata;
    endcase
  end

  // Interrupt arbitration: MEI > MSI > MTI; cause is reported regardless of mstatus.MIE.
  assign w_pend        = r_mie_en & r_mip;
  assign o_irq_pending = r_st_mie & |w_pend;
  assign w_code        = w_pend[2] ? 4'd11 : w_pend[0] ? 4'd3 : 4'd7;
  assign o_irq_cause   = |w_pend ? {1'b1, {(MXLEN-5){1'b0}}, w_code} : '0;

  assign w_base     = {r_mtvec[MXLEN-1:2], 2'b00};
  assign o_trap_vec = (r_mtvec[1:0] == 2'b01 && i_trap_cause[MXLEN-1])
                      ? w_base + {i_trap_cause[MXLEN-3:0], 2'b00} : w_base;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_st_mie   <= 1'b0;
      r_st_mpie  <= 1'b0;
      r_mie_en   <= '0;
      r_mip      <= '0;
      r_mtvec    <= RESET_MTVEC;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mtval    <= '0;
      r_mcinh    <= '0;
    end else begin
      r_mip <= {i_meip, i_mtip, i_msip};
      if (i_trap_req) begin
        r_mepc    <= {i_pc[MXLEN-1:2], 2'b00};
        r_mcause  <= i_trap_cause;
        r_mtval   <= i_trap_tval;
        r_st_mpie <= r_st_mie;
        r_st_mie  <= 1'b0;
      end else if (i_trap_mret) begin
        r_st_mie  <= r_st_mpie;
        r_st_mpie <= 1'b1;
      end else if (w_wr) begin
        case (i_addr)
          12'h300: begin
            r_st_mie  <= w_wval[3];
            r_st_mpie <= w_wval[7];
          end
          12'h304: r_mie_en <= {w_wval[11], w_wval[7], w_wval[3]};
          12'h305: r_mtvec  <= {w_wval[MXLEN-1:2],
                                (MTVEC_VECTORED && w_wval[1:0] == 2'b01) ? 2'b01 : 2'b00};
          12'h320: r_mcinh    <= w_wval & MCI_MASK;
          12'h340: r_mscratch <= w_wval;
          12'h341: r_mepc     <= {w_wval[MXLEN-1:2], 2'b00};
          12'h342: r_mcause   <= w_wval;
          12'h343: r_mtval    <= w_wval;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      r_mcycle   <= cnt_next(r_mcycle, w_wr && i_addr == 12'hB00,
                             w_wr && MXLEN == 32 && i_addr == 12'hB80, !r_mcinh[0], w_wval);
      r_minstret <= cnt_next(r_minstret, w_wr && i_addr == 12'hB02,
                             w_wr && MXLEN == 32 && i_addr == 12'hB82, i_retire && !r_mcinh[2], w_wval);
    end
  end

`ifdef COTM32_CSR_HPM_EN
  always_comb begin
    for (int k = 0; k < NUM_HPM; k++) begin
      w_hpm_wl[k] = w_wr && i_addr == {7'b1011000, 5'(k + 3)};
      w_hpm_wh[k] = w_wr && MXLEN == 32 && i_addr == {7'b1011100, 5'(k + 3)};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_HPM; k++) r_hpm[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_HPM; k++)
        r_hpm[k] <= cnt_next(r_hpm[k], w_hpm_wl[k], w_hpm_wh[k],
                             i_hpm_evt[k] && !r_mcinh[k+3], w_wval);
    end
  end
`endif

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: reset, interrupts, traps/MRET, counters, illegal access, HPM.
`timescale 1ns/1ps
module tb_csr_unit;
  import zicsr_pkg::*;

  logic          clk = 1'b0;
  logic          i_rst_n;
  zicsr_csr_op_t i_op;
  logic [11:0]   i_addr;
  logic          i_we;
  logic [31:0]   i_wdata, i_pc, i_trap_cause, i_trap_tval;
  logic          i_trap_req, i_trap_mret, i_retire, i_msip, i_mtip, i_meip;
  logic [3:0]    i_hpm_evt;
  logic [31:0]   o_rdata, o_mstatus, o_mie, o_mip, o_mepc, o_trap_vec, o_irq_cause;
  logic          o_irq_pending, o_t_illegal_inst;

  int n_chk = 0;
  int n_pass = 0;

  always #50 clk = ~clk;

  csr_unit #(.MXLEN(32), .NUM_HPM(4), .MTVEC_VECTORED(1'b1), .RESET_MTVEC(32'h0)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_op(i_op), .i_addr(i_addr), .i_we(i_we),
    .i_wdata(i_wdata), .i_pc(i_pc), .i_trap_req(i_trap_req), .i_trap_cause(i_trap_cause),
    .i_trap_tval(i_trap_tval), .i_trap_mret(i_trap_mret), .i_retire(i_retire),
    .i_msip(i_msip), .i_mtip(i_mtip), .i_meip(i_meip), .i_hpm_evt(i_hpm_evt),
    .o_rdata(o_rdata), .o_mstatus(o_mstatus), .o_mie(o_mie), .o_mip(o_mip), .o_mepc(o_mepc),
    .o_trap_vec(o_trap_vec), .o_irq_pending(o_irq_pending), .o_irq_cause(o_irq_cause),
    .o_t_illegal_inst(o_t_illegal_inst)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] expv);
    i_addr = a;
    #1;
    chk(tag, o_rdata, expv);
  endtask

  task automatic csr(input zicsr_csr_op_t op, input logic [11:0] a, input logic [31:0] d);
    i_op = op; i_addr = a; i_wdata = d; i_we = 1'b1;
    step();
    i_op = CSR_NONE; i_we = 1'b0;
  endtask

  initial begin
    i_rst_n = 1'b0; i_op = CSR_NONE; i_addr = '0; i_we = 1'b0; i_wdata = '0; i_pc = '0;
    i_trap_req = 1'b0; i_trap_cause = '0; i_trap_tval = '0; i_trap_mret = 1'b0;
    i_retire = 1'b0; i_msip = 1'b0; i_mtip = 1'b0; i_meip = 1'b0; i_hpm_evt = '0;
    #2;
    chk("rst_mstatus", o_mstatus, 32'h1800);
    chk("rst_mie", o_mie, 32'h0);
    chk("rst_mepc", o_mepc, 32'h0);
    chk("rst_irq_cause", o_irq_cause, 32'h0);
    chk("rst_irq_pending", {31'b0, o_irq_pending}, 32'h0);
    step(); step();
    i_rst_n = 1'b1;
    step(); step(); step();
    rd("mcycle_idle3", 12'hB00, 32'd3);
    rd("mcycleh_idle3", 12'hB80, 32'd0);
    rd("minstret_idle", 12'hB02, 32'd0);
    rd("mtvec_rst", 12'h305, 32'h0);
    rd("mstatus_rd", 12'h300, 32'h1800);
    rd("misa", 12'h301, 32'h4000_0100);

    // Interrupt enable, pending and vectored target.
    i_op = CSR_RW; i_addr = 12'h305; i_we = 1'b1; #1;
    chk("mtvec_legal", {31'b0, o_t_illegal_inst}, 32'h0);
    csr(CSR_RW, 12'h305, 32'h8000_0101);
    csr(CSR_RS, 12'h304, 32'h80);
    csr(CSR_RS, 12'h300, 32'h8);
    chk("mstatus_mie_set", o_mstatus, 32'h1808);
    rd("mtvec_rw", 12'h305, 32'h8000_0101);
    i_mtip = 1'b1;
    step();
    chk("mip_mtip", o_mip, 32'h80);
    chk("irq_pend_mti", {31'b0, o_irq_pending}, 32'h1);
    chk("irq_cause_mti", o_irq_cause, 32'h8000_0007);
    i_trap_cause = 32'h8000_0007; #1;
    chk("trap_vec_irq7", o_trap_vec, 32'h8000_011C);
    i_trap_cause = 32'h2; #1;
    chk("trap_vec_exc", o_trap_vec, 32'h8000_0100);
    i_meip = 1'b1;
    step();
    chk("irq_cause_mei_masked", o_irq_cause, 32'h8000_0007);
    csr(CSR_RS, 12'h304, 32'h800);
    chk("irq_cause_mei", o_irq_cause, 32'h8000_000B);
    i_meip = 1'b0; i_msip = 1'b1;
    csr(CSR_RS, 12'h304, 32'h8);
    chk("irq_cause_msi_over_mti", o_irq_cause, 32'h8000_0003);
    i_msip = 1'b0; i_mtip = 1'b0;
    step();
    chk("irq_pend_none", {31'b0, o_irq_pending}, 32'h0);
    chk("irq_cause_none", o_irq_cause, 32'h0);
    rd("mie_all", 12'h304, 32'h888);

    // Trap with simultaneous CSR write and MRET: only the trap takes effect.
    i_trap_req = 1'b1; i_trap_mret = 1'b1; i_pc = 32'h102; i_trap_cause = 32'h2;
    i_trap_tval = 32'hDEAD;
    csr(CSR_RW, 12'h340, 32'h55);
    i_trap_req = 1'b0; i_trap_mret = 1'b0;
    chk("trap_mepc", o_mepc, 32'h100);
    chk("trap_mstatus", o_mstatus, 32'h1880);
    rd("trap_mcause", 12'h342, 32'h2);
    rd("trap_mtval", 12'h343, 32'hDEAD);
    rd("trap_mscratch_kept", 12'h340, 32'h0);
    i_trap_mret = 1'b1;
    step();
    i_trap_mret = 1'b0;
    chk("mret_mstatus", o_mstatus, 32'h1888);
    csr(CSR_RW, 12'h340, 32'h55);
    rd("mscratch_rw", 12'h340, 32'h55);
    csr(CSR_RC, 12'h340, 32'h05);
    rd("mscratch_rc", 12'h340, 32'h50);
    csr(CSR_RS, 12'h340, 32'h0A);
    rd("mscratch_rs", 12'h340, 32'h5A);
    csr(CSR_RW, 12'h341, 32'h1234_5677);
    rd("mepc_align", 12'h341, 32'h1234_5674);
    csr(CSR_RW, 12'h305, 32'h202);
    rd("mtvec_mode2", 12'h305, 32'h200);
    i_trap_cause = 32'h8000_0007; #1;
    chk("trap_vec_mode0_irq", o_trap_vec, 32'h200);

    // 64-bit mcycle: write halves, carry across, inhibit.
    csr(CSR_RW, 12'hB00, 32'hFFFF_FFFE);
    csr(CSR_RW, 12'hB80, 32'h0);
    rd("mcycle_after_hwr", 12'hB00, 32'hFFFF_FFFE);
    rd("mcycleh_after_hwr", 12'hB80, 32'h0);
    step(); step();
    rd("mcycle_wrap", 12'hB00, 32'h0);
    rd("mcycleh_carry", 12'hB80, 32'h1);
    csr(CSR_RS, 12'h320, 32'h1);
    rd("mcycle_inh_start", 12'hB00, 32'h1);
    step(); step();
    rd("mcycle_frozen", 12'hB00, 32'h1);
    csr(CSR_RW, 12'h320, 32'h0);
    step();
    rd("mcycle_resumed", 12'hB00, 32'h2);
    csr(CSR_RW, 12'h320, 32'hFFFF_FFFF);
`ifdef COTM32_CSR_HPM_EN
    rd("mcinh_mask", 12'h320, 32'h7D);
`else
    rd("mcinh_mask", 12'h320, 32'h5);
`endif
    csr(CSR_RW, 12'h320, 32'h0);
    i_retire = 1'b1;
    step(); step(); step();
    i_retire = 1'b0;
    rd("minstret_3", 12'hB02, 32'd3);

    // Illegal accesses.
    i_op = CSR_RW; i_addr = 12'hF14; i_we = 1'b1; i_wdata = 32'h5; #1;
    chk("ill_ro_write", {31'b0, o_t_illegal_inst}, 32'h1);
    step();
    i_op = CSR_NONE; i_we = 1'b0;
    rd("mhartid", 12'hF14, 32'h0);
    i_op = CSR_RS; i_addr = 12'hF14; #1;
    chk("ro_read_legal", {31'b0, o_t_illegal_inst}, 32'h0);
    i_addr = 12'h7C0; #1;
    chk("ill_unimpl", {31'b0, o_t_illegal_inst}, 32'h1);
    i_op = CSR_NONE; #1;
    chk("none_legal", {31'b0, o_t_illegal_inst}, 32'h0);
    csr(CSR_RW, 12'h301, 32'h0);
    rd("misa_warl", 12'h301, 32'h4000_0100);

    // HPM counters.
    i_hpm_evt = 4'b0001;
    step(); step(); step(); step(); step();
    i_hpm_evt = 4'b0000;
`ifdef COTM32_CSR_HPM_EN
    rd("hpm3_count", 12'hB03, 32'd5);
    rd("hpm3h", 12'hB83, 32'd0);
    rd("hpm4_idle", 12'hB04, 32'd0);
    i_op = CSR_RS; i_addr = 12'hB07; #1;
    chk("hpm_beyond_illegal", {31'b0, o_t_illegal_inst}, 32'h1);
    i_op = CSR_NONE;
`else
    rd("hpm3_zero", 12'hB03, 32'd0);
    i_op = CSR_RS; i_addr = 12'hB03; #1;
    chk("hpm_legal", {31'b0, o_t_illegal_inst}, 32'h0);
    i_op = CSR_NONE;
    csr(CSR_RW, 12'hB03, 32'h7);
    rd("hpm3_wr_ignored", 12'hB03, 32'd0);
`endif

    // Asynchronous reset mid-operation.
    i_rst_n = 1'b0; #1;
    chk("async_rst_mepc", o_mepc, 32'h0);
    chk("async_rst_mstatus", o_mstatus, 32'h1800);
    rd("async_rst_mscratch", 12'h340, 32'h0);
    i_rst_n = 1'b1;
    step();
    rd("mcycle_after_rst", 12'hB00, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
